// File: rtl/sa4x4_sequencer.sv
// sa4x4_sequencer: command-level controller for the 4x4 systolic array.
// Decodes START/READ bytes from the UART rx stream. START clears the
// accumulators, runs a skewed FEED_STEPS feed window, then a DRAIN_CYCLES
// drain, then pulses o_done. READ walks o_res_sel over all results and hands
// each byte to the UART transmitter with a start/busy handshake.
// Optional: define SA_TX_CHECKSUM_EN to append an XOR checksum byte per READ.
// Ports:
//   i_clock, i_rst_n      clock, synchronous active-low reset
//   i_uart_rw, i_uart_in  rx byte-valid level (rising edge accepts) and byte
//   o_sa_clear            one-cycle accumulator clear
//   o_sa_feed_en, o_sa_step  feed window enable and step index
//   o_res_sel, i_res_data result mux select and selected byte
//   o_tx_start, o_tx_data, i_tx_busy  transmitter handshake
//   o_busy, o_done        not-idle flag and compute-complete pulse
module sa4x4_sequencer #(
    parameter logic [7:0] START_CMD    = 8'hA0,
    parameter logic [7:0] READ_CMD     = 8'hB0,
    parameter int         FEED_STEPS   = 7,
    parameter int         DRAIN_CYCLES = 3,
    parameter int         NUM_RESULTS  = 16
) (
    input  logic       i_clock,
    input  logic       i_rst_n,
    input  logic       i_uart_rw,
    input  logic [7:0] i_uart_in,
    output logic       o_sa_clear,
    output logic       o_sa_feed_en,
    output logic [2:0] o_sa_step,
    output logic [3:0] o_res_sel,
    input  logic [7:0] i_res_data,
    output logic       o_tx_start,
    output logic [7:0] o_tx_data,
    input  logic       i_tx_busy,
    output logic       o_busy,
    output logic       o_done
);
    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_TX_LOAD, S_TX_ACK, S_TX_WAIT
`ifdef SA_TX_CHECKSUM_EN
        , S_CHK
`endif
    } state_t;

    state_t     r_state;
    logic       r_rw_q;
    logic       r_sa_clear;
    logic       r_feed_en;
    logic [2:0] r_step;
    logic [7:0] r_cnt;
    logic [3:0] r_res_sel;
    logic       r_tx_start;
    logic [7:0] r_tx_data;
    logic       r_done;
`ifdef SA_TX_CHECKSUM_EN
    logic [7:0] r_sum;
    logic       r_chk;
`endif

    logic w_uart_en;
    logic w_last;

    assign w_uart_en = i_uart_rw & ~r_rw_q;
    assign w_last    = r_res_sel == 4'(NUM_RESULTS - 1);

    always_ff @(posedge i_clock) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_rw_q     <= 1'b0;
            r_sa_clear <= 1'b0;
            r_feed_en  <= 1'b0;
            r_step     <= '0;
            r_cnt      <= '0;
            r_res_sel  <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
            r_done     <= 1'b0;
`ifdef SA_TX_CHECKSUM_EN
            r_sum      <= '0;
            r_chk      <= 1'b0;
`endif
        end else begin
            r_rw_q     <= i_uart_rw;
            r_sa_clear <= 1'b0;
            r_tx_start <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_uart_en && i_uart_in == START_CMD) begin
                        r_state    <= S_CLEAR;
                        r_sa_clear <= 1'b1;
                    end else if (w_uart_en && i_uart_in == READ_CMD) begin
                        r_state   <= S_TX_LOAD;
                        r_res_sel <= '0;
`ifdef SA_TX_CHECKSUM_EN
                        r_sum     <= '0;
                        r_chk     <= 1'b0;
`endif
                    end
                end
                S_CLEAR: begin
                    r_state   <= S_FEED;
                    r_feed_en <= 1'b1;
                    r_step    <= '0;
                end
                S_FEED: begin
                    if (r_step == 3'(FEED_STEPS - 1)) begin
                        r_state   <= S_DRAIN;
                        r_feed_en <= 1'b0;
                        r_step    <= '0;
                        r_cnt     <= '0;
                    end else begin
                        r_step <= r_step + 3'd1;
                    end
                end
                S_DRAIN: begin
                    if (r_cnt == 8'(DRAIN_CYCLES - 1)) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_TX_LOAD: begin
                    if (!i_tx_busy) begin
`ifdef SA_TX_CHECKSUM_EN
                        r_tx_data <= r_chk ? r_sum : i_res_data;
                        if (!r_chk) r_sum <= r_sum ^ i_res_data;
`else
                        r_tx_data <= i_res_data;
`endif
                        r_tx_start <= 1'b1;
                        r_state    <= S_TX_ACK;
                    end
                end
                S_TX_ACK: begin
                    if (i_tx_busy) r_state <= S_TX_WAIT;
                end
                S_TX_WAIT: begin
                    if (!i_tx_busy) begin
`ifdef SA_TX_CHECKSUM_EN
                        if (r_chk) r_state <= S_IDLE;
                        else if (w_last) r_state <= S_CHK;
`else
                        if (w_last) r_state <= S_IDLE;
`endif
                        else begin
                            r_res_sel <= r_res_sel + 4'd1;
                            r_state   <= S_TX_LOAD;
                        end
                    end
                end
`ifdef SA_TX_CHECKSUM_EN
                S_CHK: begin
                    r_chk   <= 1'b1;
                    r_state <= S_TX_LOAD;
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_sa_clear   = r_sa_clear;
    assign o_sa_feed_en = r_feed_en;
    assign o_sa_step    = r_step;
    assign o_res_sel    = r_res_sel;
    assign o_tx_start   = r_tx_start;
    assign o_tx_data    = r_tx_data;
    assign o_done       = r_done;
    assign o_busy       = r_state != S_IDLE;
endmodule

// File: tb/tb_sa4x4_sequencer.sv
// tb_sa4x4_sequencer: directed self-checking bench for sa4x4_sequencer.
module tb_sa4x4_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_rw = 1'b0;
    logic [7:0] uart_in = 8'h00;
    logic       sa_clear, sa_feed_en, tx_start, tx_busy, busy, done;
    logic [2:0] sa_step;
    logic [3:0] res_sel;
    logic [7:0] res_data, tx_data;

    logic [7:0] res_mem [16];
    logic [7:0] tx_log [32];
    logic [7:0] last_tx = 8'h00;
    logic       hold_busy = 1'b0;
    int         busy_cnt = 0;
    int         n_tx = 0, n_clear = 0, n_done = 0;
    int         n_vec = 0, n_err = 0;
`ifdef SA_TX_CHECKSUM_EN
    localparam int NBYTES = 17;
`else
    localparam int NBYTES = 16;
`endif

    sa4x4_sequencer dut (
        .i_clock(clk), .i_rst_n(rst_n), .i_uart_rw(uart_rw), .i_uart_in(uart_in),
        .o_sa_clear(sa_clear), .o_sa_feed_en(sa_feed_en), .o_sa_step(sa_step),
        .o_res_sel(res_sel), .i_res_data(res_data), .o_tx_start(tx_start),
        .o_tx_data(tx_data), .i_tx_busy(tx_busy), .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    assign res_data = res_mem[res_sel];
    assign tx_busy  = (busy_cnt > 0) || hold_busy;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Transmitter model: 4-cycle busy per tx_start, logging each byte.
    always @(negedge clk) begin
        if (busy_cnt > 0) chk("tx_data_stable", tx_data, last_tx);
        if (busy_cnt > 0) busy_cnt--;
        if (tx_start) begin
            if (n_tx < 32) tx_log[n_tx] = tx_data;
            n_tx++;
            last_tx  = tx_data;
            busy_cnt = 4;
        end
        if (sa_clear) n_clear++;
        if (done) n_done++;
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        uart_in = b;
        uart_rw = 1'b1;
        @(posedge clk); #1;
        uart_rw = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 600; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("idle_timeout", busy, 0);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_clear"}, sa_clear, 0);
        chk({tag, "_feed"}, sa_feed_en, 0);
        chk({tag, "_step"}, sa_step, 0);
        chk({tag, "_ressel"}, res_sel, 0);
        chk({tag, "_txstart"}, tx_start, 0);
        chk({tag, "_txdata"}, tx_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    task automatic check_read(input string tag);
        logic [7:0] x;
        x = 8'h00;
        chk({tag, "_count"}, n_tx, NBYTES);
        for (int i = 0; i < 16; i++) begin
            chk({tag, "_byte"}, tx_log[i], res_mem[i]);
            x ^= res_mem[i];
        end
`ifdef SA_TX_CHECKSUM_EN
        chk({tag, "_cksum"}, tx_log[16], x);
`endif
        chk({tag, "_ressel_hold"}, res_sel, 4'd15);
    endtask

    task automatic do_read(input string tag);
        n_tx = 0;
        send_byte(8'hB0);
        wait_idle();
        check_read(tag);
    endtask

    initial begin
        int c0, d0, k;
        for (int i = 0; i < 16; i++) res_mem[i] = 8'h10 + 8'(i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        // START timing: strobe in cycle T, check T+1..T+13
        @(posedge clk); #1;
        uart_in = 8'hA0;
        uart_rw = 1'b1;
        for (int n = 1; n <= 13; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 1) uart_rw = 1'b0;
            chk("start_clear", sa_clear, n == 1);
            chk("start_feed", sa_feed_en, n >= 2 && n <= 8);
            chk("start_step", sa_step, (n >= 2 && n <= 8) ? n - 2 : 0);
            chk("start_done", done, n == 12);
            chk("start_busy", busy, n < 12);
        end

        // Non-command bytes ignored, held level gives one pass
        c0 = n_clear;
        send_byte(8'h02);
        send_byte(8'h55);
        repeat (3) @(negedge clk);
        chk("noncmd_busy", busy, 0);
        chk("noncmd_clear", n_clear, c0);
        d0 = n_done;
        @(posedge clk); #1;
        uart_in = 8'hA0;
        uart_rw = 1'b1;
        repeat (5) @(posedge clk);
        #1 uart_rw = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        chk("held_clears", n_clear, c0 + 1);
        chk("held_dones", n_done, d0 + 1);

        // READ with 4-cycle transmitter
        do_read("read");

        // READ while transmitter busy, START during readout ignored
        c0 = n_clear;
        d0 = n_done;
        hold_busy = 1'b1;
        n_tx = 0;
        send_byte(8'hB0);
        repeat (8) @(negedge clk);
        chk("withheld_tx", n_tx, 0);
        chk("withheld_busy", busy, 1);
        send_byte(8'hA0);
        @(negedge clk);
        hold_busy = 1'b0;
        repeat (20) @(negedge clk);
        send_byte(8'hA0);
        wait_idle();
        check_read("busyread");
        chk("busyread_noclear", n_clear, c0);
        chk("busyread_nodone", n_done, d0);

        // Reset mid-FEED at step 3
        send_byte(8'hA0);
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (sa_feed_en && sa_step == 3'd3) break;
        end
        chk("midfeed_reached", k < 20, 1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_zero("midreset");
        rst_n = 1'b1;
        c0 = n_clear;
        d0 = n_done;
        send_byte(8'hA0);
        wait_idle();
        repeat (2) @(negedge clk);
        chk("post_reset_clear", n_clear, c0 + 1);
        chk("post_reset_done", n_done, d0 + 1);

        // Second data pattern: single 01 at index 0
        for (int i = 0; i < 16; i++) res_mem[i] = 8'h00;
        res_mem[0] = 8'h01;
        do_read("read01");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sa4x4_sequencer.md
Name: sa4x4_sequencer

Overview:
Command-level controller for the 4x4 systolic array. It watches the UART receive byte stream for two commands: START runs one compute pass, and READ streams the result bytes back out. For a compute pass it clears the accumulators, drives a skewed 7-step feed window and a drain period. For READ it walks the result mux and hands bytes to the UART transmitter under a start/busy handshake. Operand-capture blocks share the same rx stream and own all other byte values.

Parameters:
START_CMD, 8'hA0, rx byte that starts a compute pass
READ_CMD, 8'hB0, rx byte that starts result readout
FEED_STEPS, 7, number of feed cycles (2N-1 for N=4)
DRAIN_CYCLES, 3, cycles after the last feed before compute counts as complete
NUM_RESULTS, 16, result bytes sent per READ

Ports:
Clock  in  1  system clock
rst_n  in  1  reset; synchronous, active-low; sampled only on the rising edge of Clock
uart_rw  in  1  rx byte-valid level; a byte is accepted on its rising edge
uart_in  in  8  rx byte
sa_clear  out  1  one-cycle pulse that clears the array accumulators
sa_feed_en  out  1  high during feed cycles
sa_step  out  3  feed step index 0..FEED_STEPS-1; 0 when not feeding
res_sel  out  4  result index presented to the array output mux
res_data  in  8  result byte selected by res_sel (combinational)
tx_start  out  1  one-cycle request to the UART transmitter
tx_data  out  8  byte to transmit; held stable from tx_start until tx_busy falls
tx_busy  in  1  transmitter busy
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a compute pass finishes

Behaviour:
- Reset (rst_n low at a Clock edge): state=IDLE. All outputs are 0, including tx_data and res_sel. The edge-detect register is cleared. Applies mid-compute and mid-transmit; no partial transfer resumes.
- Byte strobe: uart_en = uart_rw & !uart_rw_q, where uart_rw_q is uart_rw registered. One byte per rising edge. A level held high gives exactly one strobe.
- IDLE:
  - uart_en with START_CMD -> CLEAR.
  - uart_en with READ_CMD -> TX_LOAD, res_sel=0.
  - Any other byte is ignored.
- CLEAR: sa_clear=1 for exactly one cycle -> FEED, step counter=0.
- FEED: sa_feed_en=1 and sa_step=counter. The counter increments each cycle. When counter reaches FEED_STEPS-1 -> DRAIN, counter=0.
- DRAIN: counts DRAIN_CYCLES cycles, then -> IDLE with done=1 for one cycle (registered with the transition).
- Compute latency: START strobe at cycle T gives:
  - sa_clear at T+1
  - feed at T+2..T+8
  - done at T+8+DRAIN_CYCLES+1 = T+12 with defaults
- TX_LOAD: waits while tx_busy=1. When tx_busy=0, register tx_data<=res_data, pulse tx_start for one cycle -> TX_ACK.
- TX_ACK: waits for tx_busy=1 -> TX_WAIT. No timeout; a transmitter that never asserts busy stalls here until reset.
- TX_WAIT: waits for tx_busy=0.
  - If res_sel==NUM_RESULTS-1 -> IDLE (or CHK, see Optional Feature).
  - Otherwise res_sel+1 -> TX_LOAD.
- res_sel holds its last value in IDLE until the next READ command resets it to 0.
- Commands arriving while busy=1 are dropped. They are not queued, and the edge-detect register still tracks uart_rw.
- A START strobe and a READ strobe cannot coincide, since one byte arrives per strobe.
- sa_step width is 3 bits; FEED_STEPS must be ≤8. Counters do not wrap beyond their terminal values.

Optional Feature:
Macro SA_TX_CHECKSUM_EN.
- Defined:
  - An 8-bit XOR accumulator is cleared on READ acceptance and XORs in every transmitted result byte.
  - After the last result, state CHK sends the accumulator as one extra byte, using the same TX_LOAD/ACK/WAIT handshake, then -> IDLE.
  - Total bytes per READ = NUM_RESULTS+1.
- Undefined: no accumulator and no CHK state; exactly NUM_RESULTS bytes per READ.

Test Plan:
1. Reset mid-FEED: after START, assert rst_n=0 at feed step 3 -> next cycle all outputs 0, busy=0; a later START runs a full pass normally.
2. START (8'hA0) strobe at cycle T -> sa_clear high only at T+1; sa_feed_en at T+2..T+8 with sa_step 0..6; done pulse at T+12; busy falls the same cycle.
3. Non-command bytes 8'h02, 8'h55 in IDLE -> no state change. uart_rw held high for 5 cycles carrying 8'hA0 -> exactly one compute pass.
4. READ (8'hB0), res_data=8'h10+res_sel, transmitter model with 4-cycle busy -> 16 tx_start pulses carrying 8'h10..8'h1F in order; tx_data stable during busy; back to IDLE.
5. READ issued while tx_busy is already high -> first tx_start is withheld until busy falls. START sent during the readout -> ignored and no sa_clear occurs.
6. With SA_TX_CHECKSUM_EN and the same data as scenario 4 -> 17th byte = XOR of 8'h10..8'h1F = 8'h00. Repeat with res_data=8'h01 at index 0, others 8'h00 -> checksum 8'h01.
